serial_load_lut_dbuf: RTL and testbench

- Parametrised, double-buffered successor to the team's serial-load LUT, used as a configurable lookup element behind the TinyTapeout io_in/io_out wrapper.
- Configuration is shifted serially into a shadow register while cs_n is low.
- On cs_n release, the frame commits atomically to the active table, but only if exactly the right number of bits arrived. A short or long frame is rejected and flagged.
- The active table drives the lookup output throughout loading, so the LUT never glitches mid-reprogram. A serial readback pin and an optional registered-output mode are also provided.

---
 rtl/serial_load_lut_dbuf_pkg.sv | 24 ++
 rtl/serial_frame_rx.sv | 43 ++++
 rtl/serial_load_lut_dbuf.sv | 81 ++++++++
 tb/tb_serial_load_lut_dbuf.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_load_lut_dbuf_pkg.sv
// Shared definitions for the double-buffered serial-load LUT:
// table-width helper and the default TinyTapeout pin mapping.
package serial_load_lut_dbuf_pkg;

  // Configuration frame length: one OUT_W-bit entry per select code.
  function automatic int unsigned cfg_w(input int unsigned sel_w, input int unsigned out_w);
    return out_w * (32'd1 << sel_w);
  endfunction

  // Default TinyTapeout pin-out (SEL_W = 4, OUT_W = 4).
  localparam int unsigned TT_IO_W        = 8;
  localparam int unsigned TT_IN_D        = 0;
  localparam int unsigned TT_IN_CLK      = 1;
  localparam int unsigned TT_IN_RST_N    = 2;
  localparam int unsigned TT_IN_CS_N     = 3;
  localparam int unsigned TT_IN_SEL_LSB  = 4;
  localparam int unsigned TT_IN_SEL_MSB  = 7;
  localparam int unsigned TT_OUT_LSB     = 0;
  localparam int unsigned TT_OUT_MSB     = 3;
  localparam int unsigned TT_OUT_Q       = 4;
  localparam int unsigned TT_OUT_CFG_VLD = 5;
  localparam int unsigned TT_OUT_FRM_ERR = 6;

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: shadow shifter, saturating bit counter,
// cs_n release detection and frame-length qualification.
module serial_frame_rx #(
  parameter int unsigned CFG_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             d,
  output logic [CFG_W-1:0] shadow,
  output logic             commit_pulse,
  output logic             len_ok
);

  localparam int unsigned      CNT_W    = $clog2(CFG_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

  logic [CNT_W-1:0] cnt;
  logic             cs_q;

  // Shift while selected; counter saturates one past a full frame so
  // over-long frames can never alias back to the correct length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      cnt    <= '0;
      cs_q   <= 1'b1;
    end else begin
      cs_q <= cs_n;
      if (!cs_n) begin
        shadow <= {shadow[CFG_W-2:0], d};
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign commit_pulse = ~cs_q & cs_n;
  assign len_ok       = (cnt == CNT_FULL);

endmodule

// File: rtl/serial_load_lut_dbuf.sv
// Double-buffered serial-load LUT: frames commit atomically from the
// shadow register to the active table, which alone drives the lookup.
module serial_load_lut_dbuf
  import serial_load_lut_dbuf_pkg::*;
#(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned OUT_W   = 4,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             d,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic             q,
  output logic             cfg_valid,
  output logic             frame_err
);

  localparam int unsigned CFG_W = cfg_w(SEL_W, OUT_W);
  localparam int unsigned DEPTH = 32'd1 << SEL_W;

  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] active;
  logic             commit_pulse;
  logic             len_ok;
  logic [OUT_W-1:0] lookup;

  serial_frame_rx #(.CFG_W(CFG_W)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs_n         (cs_n),
    .d            (d),
    .shadow       (shadow),
    .commit_pulse (commit_pulse),
    .len_ok       (len_ok)
  );

  // Only a correct-length frame replaces the table; a bad one just flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
    end else if (commit_pulse) begin
      if (len_ok) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
        frame_err <= 1'b0;
      end else begin
        frame_err <= 1'b1;
      end
    end
  end

  // Entry i lives at active[i*OUT_W +: OUT_W].
  always_comb begin
    lookup = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i)) lookup = active[i*OUT_W +: OUT_W];
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [OUT_W-1:0] out_q;

    // Registered lookup samples the pre-edge table on a commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= lookup;
    end

    assign out = out_q;
  end else begin : g_comb_out
    assign out = lookup;
  end

  assign q = shadow[CFG_W-1];

endmodule

// File: tb/tb_serial_load_lut_dbuf.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor
// pops and compares against a combinational and a registered-output DUT.
module tb_serial_load_lut_dbuf;

  localparam logic [63:0] TBL_ID  = 64'hFEDCBA9876543210;
  localparam logic [63:0] TBL_REV = 64'h0123456789ABCDEF;

  typedef struct {
    string       name;
    int          kind;   // 0 out, 1 cfg_valid, 2 frame_err, 3 q, 4 registered out
    logic [3:0]  exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       d = 1'b0;
  logic [3:0] sel = '0;

  logic [3:0] out_c, out_r;
  logic       q_c, q_r, vld_c, vld_r, err_c, err_r;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_load_lut_dbuf #(.SEL_W(4), .OUT_W(4), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .d(d), .sel(sel),
    .out(out_c), .q(q_c), .cfg_valid(vld_c), .frame_err(err_c)
  );

  serial_load_lut_dbuf #(.SEL_W(4), .OUT_W(4), .REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .d(d), .sel(sel),
    .out(out_r), .q(q_r), .cfg_valid(vld_r), .frame_err(err_r)
  );

  // Monitor: every pending expectation is checked away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t       c;
      logic [3:0] act;
      c = sb.pop_front();
      case (c.kind)
        0:       act = out_c;
        1:       act = {3'b0, vld_c};
        2:       act = {3'b0, err_c};
        3:       act = {3'b0, q_c};
        default: act = out_r;
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic expect_v(input string name, input int kind, input logic [3:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  // Advance past one rising edge; inputs change 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Shift n bits of frame (MSB first from bit n-1), then release cs_n and
  // give the commit edge. Optional per-bit checks: held lookup and readback.
  task automatic send_frame(input logic [127:0] frame, input int n,
                            input int hold_exp, input bit rb,
                            input logic [63:0] prev);
    cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = frame[n-1-i];
      if (hold_exp >= 0) expect_v("out_held_during_load", 0, 4'(hold_exp));
      if (rb) expect_v("q_readback", 3, {3'b0, prev[63-i]});
      tick();
    end
    cs_n = 1'b1;
    d    = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    expect_v("rst_out", 0, 4'h0);
    expect_v("rst_cfg_valid", 1, 4'h0);
    expect_v("rst_frame_err", 2, 4'h0);
    expect_v("rst_q", 3, 4'h0);
    expect_v("rst_out_reg", 4, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Identity table load and full sweep
    send_frame({64'h0, TBL_ID}, 64, -1, 1'b0, 64'h0);
    expect_v("id_cfg_valid", 1, 4'h1);
    expect_v("id_frame_err", 2, 4'h0);
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i);
      expect_v("id_sweep", 0, 4'(i));
      tick();
    end

    // Reload with sel held: lookup must not move; q streams old table out
    sel = 4'd3;
    send_frame({64'h0, TBL_REV}, 64, 3, 1'b1, TBL_ID);
    expect_v("rev_out_sel3", 0, 4'hC);
    expect_v("rev_cfg_valid", 1, 4'h1);
    tick();

    // Back to identity, reading back the reversed table
    sel = 4'd5;
    send_frame({64'h0, TBL_ID}, 64, 12 - 2, 1'b1, TBL_REV); // entry 5 of REV is A
    expect_v("id2_out_sel5", 0, 4'h5);

    // Short frame rejected
    send_frame({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 63, 5, 1'b0, 64'h0);
    expect_v("short_frame_err", 2, 4'h1);
    expect_v("short_cfg_valid", 1, 4'h1);
    expect_v("short_out_sel5", 0, 4'h5);
    tick();

    // Long frame rejected
    sel = 4'd7;
    send_frame(128'h0, 65, 7, 1'b0, 64'h0);
    expect_v("long_frame_err", 2, 4'h1);
    expect_v("long_out_sel7", 0, 4'h7);
    tick();

    // Good frame clears the error flag
    send_frame({64'h0, TBL_ID}, 64, -1, 1'b0, 64'h0);
    expect_v("good_clears_err", 2, 4'h0);
    expect_v("good_cfg_valid", 1, 4'h1);

    // Registered output: one edge of latency on sel change
    sel = 4'd2;
    tick();
    tick();
    expect_v("reg_out_sel2", 4, 4'h2);
    expect_v("comb_out_sel2", 0, 4'h2);
    tick();
    sel = 4'd9;
    expect_v("reg_out_before_edge", 4, 4'h2);
    expect_v("comb_out_sel9", 0, 4'h9);
    tick();
    expect_v("reg_out_after_edge", 4, 4'h9);
    tick();

    // Reset asserted at bit 30 of a frame clears everything at once
    cs_n = 1'b0;
    d    = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    rst_n = 1'b0;
    expect_v("midrst_out", 0, 4'h0);
    expect_v("midrst_cfg_valid", 1, 4'h0);
    expect_v("midrst_q", 3, 4'h0);
    expect_v("midrst_out_reg", 4, 4'h0);
    expect_v("midrst_frame_err", 2, 4'h0);
    tick();
    cs_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    expect_v("post_rst_cfg_valid", 1, 4'h0);
    tick();

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
